// File: rtl/mult_pkg.sv
// mult_pkg: state encoding, iteration count and Booth code constants shared by mult_booth.
package mult_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
    localparam int MULT_ITER = 32;
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;
endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration on {ACC,Q,q_1}.
import mult_pkg::*;
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);
    logic [1:0]     w_code;
    logic [WIDTH:0] w_sum;
    always_comb begin
        w_code = {i_q[0], i_q1};
        w_sum  = (w_code == BOOTH_ADD) ? i_acc + i_m :
                 (w_code == BOOTH_SUB) ? i_acc - i_m : i_acc;
        o_acc  = {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_q    = {w_sum[0], i_q[WIDTH-1:1]};
        o_q1   = i_q[0];
    end
endmodule

// File: rtl/mult_booth.sv
// mult_booth: sequential signed WIDTHxWIDTH radix-2 Booth multiplier with one-cycle mult_end pulse.
// Optional MULT_ZERO_SKIP_EN: a zero operand finishes at the start edge with a zero product.
import mult_pkg::*;
module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_control,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out,
    output logic             mult_end,
    output logic             mult_busy
);
    state_t           r_state, w_next;
    logic [WIDTH:0]   r_m, r_acc, w_acc;
    logic [WIDTH-1:0] r_q, w_q;
    logic             r_q1, w_q1;
    logic [5:0]       r_cnt;
    logic             w_start, w_last, w_zero;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_acc(r_acc), .i_q(r_q), .i_q1(r_q1), .i_m(r_m),
        .o_acc(w_acc), .o_q(w_q), .o_q1(w_q1)
    );

    always_comb begin
        w_start = (r_state == IDLE) && mult_control;
        w_last  = (r_state == RUN) && (r_cnt == 6'(MULT_ITER - 1));
`ifdef MULT_ZERO_SKIP_EN
        w_zero  = (A_in == '0) || (B_in == '0);
`else
        w_zero  = 1'b0;
`endif
        w_next  = (r_state == RUN)  ? (w_last ? DONE : RUN) :
                  (r_state == DONE) ? IDLE :
                  w_start           ? (w_zero ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // HI/LO only change on completion so the register file sees a stable result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            HI_out    <= '0;
            LO_out    <= '0;
            mult_end  <= 1'b0;
            mult_busy <= 1'b0;
        end else begin
            if (w_start) begin
                r_m   <= {A_in[WIDTH-1], A_in};
                r_acc <= '0;
                r_q   <= B_in;
                r_q1  <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_acc <= w_acc;
                r_q   <= w_q;
                r_q1  <= w_q1;
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_last) begin
                HI_out <= w_acc[WIDTH-1:0];
                LO_out <= w_q;
            end else if (w_start && w_zero) begin
                HI_out <= '0;
                LO_out <= '0;
            end
            mult_end  <= (w_next == DONE);
            mult_busy <= (w_next == RUN);
        end
    end
endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth: directed vectors with a scoreboard queue checked by an independent mult_end monitor.
module tb_mult_booth;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mult_control = 1'b0;
    logic [31:0] A_in = '0;
    logic [31:0] B_in = '0;
    logic [31:0] HI_out, LO_out;
    logic        mult_end, mult_busy;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ends_seen = 0;
    logic prev_end = 1'b0;

    mult_booth #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .mult_control(mult_control),
        .A_in(A_in), .B_in(B_in), .HI_out(HI_out), .LO_out(LO_out),
        .mult_end(mult_end), .mult_busy(mult_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_SKIP_EN
        return (a == 32'd0 || b == 32'd0) ? 0 : 32;
`else
        return 32;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (prev_end) chk("end_single_cycle", {63'd0, mult_end}, 64'd0);
        if (mult_end) begin
            ends_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_end", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", {HI_out, LO_out}, e.prod);
                chk("end_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        prev_end = mult_end;
    end

    // Starts at a negedge, leaves the bench at the negedge right after the start edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p, input bit push);
        exp_t e;
        @(negedge clk);
        A_in = a;
        B_in = b;
        mult_control = 1'b1;
        e.prod = p;
        e.cyc = cyc + 1 + lat(a, b);
        if (push) sb.push_back(e);
        @(negedge clk);
        mult_control = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 120 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", {32'd0, HI_out}, 64'd0);
        chk("rst_lo", {32'd0, LO_out}, 64'd0);
        chk("rst_end", {63'd0, mult_end}, 64'd0);
        chk("rst_busy", {63'd0, mult_busy}, 64'd0);

        start(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
        chk("busy_run", {63'd0, mult_busy}, 64'd1);
        repeat (10) @(negedge clk);
        chk("hold_during_run", {HI_out, LO_out}, 64'd0);
        drain();
        chk("busy_after", {63'd0, mult_busy}, 64'd0);

        start(32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        drain();
        start(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        drain();

        start(32'd7, 32'd9, 64'd63, 1'b1);
        repeat (9) @(negedge clk);
        mult_control = 1'b1;
        @(negedge clk);
        mult_control = 1'b0;
        drain();
        n = ends_seen;
        repeat (40) @(negedge clk);
        chk("no_restart_end", 64'(ends_seen), 64'(n));
        chk("no_restart_busy", {63'd0, mult_busy}, 64'd0);
        chk("hold_63", {HI_out, LO_out}, 64'd63);

        // Held start runs back-to-back operations 34 cycles apart.
        begin
            exp_t e1, e2;
            @(negedge clk);
            A_in = 32'd2;
            B_in = 32'hFFFF_FFFD;
            mult_control = 1'b1;
            e1.prod = 64'hFFFF_FFFF_FFFF_FFFA;
            e1.cyc = cyc + 33;
            e2.prod = 64'hFFFF_FFFF_FFFF_FFFA;
            e2.cyc = cyc + 67;
            sb.push_back(e1);
            sb.push_back(e2);
            repeat (35) @(negedge clk);
            mult_control = 1'b0;
            drain();
        end

        start(32'd7, 32'd9, 64'd0, 1'b0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_hilo", {HI_out, LO_out}, 64'd0);
        chk("arst_end", {63'd0, mult_end}, 64'd0);
        chk("arst_busy", {63'd0, mult_busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        n = ends_seen;
        repeat (40) @(negedge clk);
        chk("arst_no_end", 64'(ends_seen), 64'(n));

        start(32'd0, 32'h0000_1234, 64'd0, 1'b1);
        chk("zero_busy", {63'd0, mult_busy}, (lat(32'd0, 32'h1234) != 0) ? 64'd1 : 64'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
